// File: rtl/disp_pkg.sv
// Shared display definitions: FSM state encoding, glyph width, blank segment
// pattern and named glyph codes used by the scroller and the display top.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SCROLL = 2'd2
    } scroll_state_t;

    localparam int GLYPH_W = 4;

    localparam logic [6:0] BLANK_SEG = 7'h7F;

    localparam logic [GLYPH_W-1:0] GLYPH_H = 4'h3;
    localparam logic [GLYPH_W-1:0] GLYPH_E = 4'hE;
    localparam logic [GLYPH_W-1:0] GLYPH_L = 4'h6;
    localparam logic [GLYPH_W-1:0] GLYPH_P = 4'h2;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll-rate prescaler: counts TICK_DIV cycles while enabled and emits a
// one-cycle step pulse on the last count. A synchronous clear restarts the
// count from zero and suppresses the pulse in that cycle.
module scroll_tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic step
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] tick;

    // Free-running prescale count that wraps at TICK_DIV-1 and restarts on clear
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tick <= '0;
        end else if (enable) begin
            if (tick == TICK_MAX) begin
                tick <= '0;
            end else begin
                tick <= tick + TICK_W'(1);
            end
        end
    end

    assign step = enable && !clear && (tick == TICK_MAX);

endmodule

// File: rtl/msg_scroll_ctrl.sv
// Message scroller feeding the per-digit seven-segment decoders.
// Buffers a message of glyph codes and slides a NUM_DIGITS-wide window over it,
// one position per TICK_DIV clocks. Optional macro SCROLL_LOOP_EN adds loop_i,
// which keeps the pass repeating instead of returning to IDLE.
module msg_scroll_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int MSG_DEPTH  = 16,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_valid_i,
    output logic                          load_ready_o,
    input  logic [GLYPH_W-1:0]            load_code_i,
    input  logic                          load_last_i,
    input  logic                          start_i,
`ifdef SCROLL_LOOP_EN
    input  logic                          loop_i,
`endif
    output logic                          busy_o,
    output logic                          done_o,
    output logic [GLYPH_W*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]         blank_o
);

    localparam int PTR_W = $clog2(MSG_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MSG_DEPTH - 1);

    scroll_state_t state, state_next;

    logic [GLYPH_W-1:0] msg_buf [MSG_DEPTH];

    logic [PTR_W-1:0] wr_ptr, wr_ptr_next;
    logic [PTR_W-1:0] offset, offset_next;
    logic [PTR_W:0]   len, len_next;

    logic accept;
    logic wr_en;
    logic scroll_active;
    logic tick_clear;
    logic step;
    logic last_offset;
    logic done_pulse;
    logic loop_en;

    logic [GLYPH_W*NUM_DIGITS-1:0] win_code;
    logic [NUM_DIGITS-1:0]         win_vis;

`ifdef SCROLL_LOOP_EN
    assign loop_en = loop_i;
`else
    assign loop_en = 1'b0;
`endif

    assign scroll_active = (state == ST_SCROLL);
    assign accept        = load_valid_i && !scroll_active;
    assign last_offset   = (({1'b0, offset} + (PTR_W+1)'(1)) == len);

    scroll_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (tick_clear),
        .enable (scroll_active),
        .step   (step)
    );

    // Next-state decode for loading, starting, stepping and ending a pass
    always_comb begin
        state_next  = state;
        wr_ptr_next = wr_ptr;
        len_next    = len;
        offset_next = offset;
        wr_en       = 1'b0;
        tick_clear  = 1'b1;
        done_pulse  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (load_last_i) begin
                        len_next    = (PTR_W+1)'(1);
                        wr_ptr_next = '0;
                    end else begin
                        wr_ptr_next = PTR_W'(1);
                        state_next  = ST_LOAD;
                    end
                end else if (start_i && (len != '0)) begin
                    offset_next = '0;
                    state_next  = ST_SCROLL;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en = 1'b1;
                    if (load_last_i || (wr_ptr == PTR_LAST)) begin
                        len_next    = {1'b0, wr_ptr} + (PTR_W+1)'(1);
                        wr_ptr_next = '0;
                        state_next  = ST_IDLE;
                    end else begin
                        wr_ptr_next = wr_ptr + PTR_W'(1);
                    end
                end
            end
            ST_SCROLL: begin
                tick_clear = 1'b0;
                if (start_i) begin
                    tick_clear  = 1'b1;
                    offset_next = '0;
                end else if (step) begin
                    if (last_offset) begin
                        done_pulse  = 1'b1;
                        offset_next = '0;
                        if (!loop_en) begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        offset_next = offset + PTR_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Control state register; reset discards any message in progress
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            wr_ptr <= '0;
            len    <= '0;
            offset <= '0;
        end else begin
            state  <= state_next;
            wr_ptr <= wr_ptr_next;
            len    <= len_next;
            offset <= offset_next;
        end
    end

    // Message storage; contents survive reset and are hidden by len instead
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            msg_buf[wr_ptr] <= load_code_i;
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_win
        localparam logic [PTR_W-1:0] K_OFF = PTR_W'(k);
        assign win_vis[k] = (state_next == ST_SCROLL) &&
                            ((32'(offset_next) + 32'(k)) < 32'(len));
        assign win_code[GLYPH_W*k +: GLYPH_W] =
            win_vis[k] ? msg_buf[offset_next + K_OFF] : '0;
    end

    // Registered display window, aligned with the offset it is built from
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digits_o <= '0;
            blank_o  <= '1;
        end else begin
            digits_o <= win_code;
            blank_o  <= ~win_vis;
        end
    end

    assign load_ready_o = !scroll_active;
    assign busy_o       = scroll_active;
    assign done_o       = done_pulse && !rst_i;

endmodule

// File: tb/tb_msg_scroll_ctrl.sv
// Self-checking bench for msg_scroll_ctrl with TICK_DIV=4: a vector table for
// the basic load/scroll pass plus hand sequences for the multi-cycle corners.
// Build with SCROLL_LOOP_EN defined to also cover the looping pass.
module tb_msg_scroll_ctrl;
    import disp_pkg::*;

    typedef struct {
        string       name;
        logic        valid;
        logic [3:0]  code;
        logic        last;
        logic        start;
        logic        exp_ready;
        logic        exp_busy;
        logic        exp_done;
        logic [15:0] exp_digits;
        logic [3:0]  exp_blank;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [3:0]  load_code;
    logic        load_last;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic [3:0]  blank;
`ifdef SCROLL_LOOP_EN
    logic        loop;
`endif

    int errors = 0;
    int checks = 0;

    vec_t vecs[$];

    msg_scroll_ctrl #(
        .NUM_DIGITS (4),
        .MSG_DEPTH  (16),
        .TICK_DIV   (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_code_i  (load_code),
        .load_last_i  (load_last),
        .start_i      (start),
`ifdef SCROLL_LOOP_EN
        .loop_i       (loop),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .digits_o     (digits),
        .blank_o      (blank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic [3:0] c,
                                  input logic l, input logic s);
        load_valid = v;
        load_code  = c;
        load_last  = l;
        start      = s;
        #1;
    endtask

    task automatic idle_cycles(input int n);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        repeat (n) tick();
    endtask

    task automatic check_output(input string name, input logic e_ready,
                                input logic e_busy, input logic e_done,
                                input logic [15:0] e_digits,
                                input logic [3:0] e_blank);
        checks++;
        if (load_ready !== e_ready || busy !== e_busy || done !== e_done ||
            digits !== e_digits || blank !== e_blank) begin
            errors++;
            $display("[TB] FAIL %s: got ready=%b busy=%b done=%b digits=%h blank=%b, want ready=%b busy=%b done=%b digits=%h blank=%b",
                     name, load_ready, busy, done, digits, blank,
                     e_ready, e_busy, e_done, e_digits, e_blank);
        end
    endtask

    function automatic vec_t mk(input string n, input logic v, input logic [3:0] c,
                                input logic l, input logic s, input logic er,
                                input logic eb, input logic ed,
                                input logic [15:0] edig, input logic [3:0] ebl);
        vec_t r;
        r.name = n; r.valid = v; r.code = c; r.last = l; r.start = s;
        r.exp_ready = er; r.exp_busy = eb; r.exp_done = ed;
        r.exp_digits = edig; r.exp_blank = ebl;
        return r;
    endfunction

    initial begin
        logic [15:0] row_dig;
        logic [3:0]  row_blk;
        int          waited;

        // HELP message load, start, then one full pass cycle by cycle
        vecs.push_back(mk("load_h", 1, GLYPH_H, 0, 0, 1, 0, 0, 16'h0000, 4'hF));
        vecs.push_back(mk("load_e", 1, GLYPH_E, 0, 0, 1, 0, 0, 16'h0000, 4'hF));
        vecs.push_back(mk("load_l", 1, GLYPH_L, 0, 0, 1, 0, 0, 16'h0000, 4'hF));
        vecs.push_back(mk("load_p", 1, GLYPH_P, 1, 0, 1, 0, 0, 16'h0000, 4'hF));
        vecs.push_back(mk("start",  0, 4'h0,    0, 1, 1, 0, 0, 16'h0000, 4'hF));
        for (int c = 1; c <= 16; c++) begin
            if (c <= 4)       begin row_dig = 16'h26E3; row_blk = 4'b0000; end
            else if (c <= 8)  begin row_dig = 16'h026E; row_blk = 4'b1000; end
            else if (c <= 12) begin row_dig = 16'h0026; row_blk = 4'b1100; end
            else              begin row_dig = 16'h0002; row_blk = 4'b1110; end
            vecs.push_back(mk($sformatf("scroll_c%0d", c), 0, 4'h0, 0, 0,
                              0, 1, (c == 16), row_dig, row_blk));
        end
        vecs.push_back(mk("after_pass", 0, 4'h0, 0, 0, 1, 0, 0, 16'h0000, 4'hF));

`ifdef SCROLL_LOOP_EN
        loop = 1'b0;
`endif
        rst = 1'b1;
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_output("reset_state", 1, 0, 0, 16'h0000, 4'hF);
        rst = 1'b0;

        // start with an empty message is ignored
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        check_output("start_empty_now", 1, 0, 0, 16'h0000, 4'hF);
        tick();
        check_output("start_empty_next", 1, 0, 0, 16'h0000, 4'hF);
        tick();
        check_output("start_empty_later", 1, 0, 0, 16'h0000, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i].valid, vecs[i].code, vecs[i].last, vecs[i].start);
            check_output(vecs[i].name, vecs[i].exp_ready, vecs[i].exp_busy,
                         vecs[i].exp_done, vecs[i].exp_digits, vecs[i].exp_blank);
            tick();
        end

        // load attempts during SCROLL are refused and leave the buffer intact
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        for (int c = 1; c <= 4; c++) begin
            apply_stimulus(1'b1, 4'hF, 1'b1, 1'b0);
            check_output("load_in_scroll", 0, 1, 0, 16'h26E3, 4'b0000);
            tick();
        end
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        waited = 0;
        while (done !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL done_timeout: got done=%b after %0d cycles, want done=1", done, waited);
        end
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("buf_unchanged", 0, 1, 0, 16'h26E3, 4'b0000);

        // restart coinciding with the final step suppresses done
        idle_cycles(15);
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        check_output("restart_final_step", 0, 1, 0, 16'h0002, 4'b1110);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("restart_window", 0, 1, 0, 16'h26E3, 4'b0000);
        idle_cycles(15);
        check_output("restart_done", 0, 1, 1, 16'h0002, 4'b1110);
        tick();
        check_output("restart_idle", 1, 0, 0, 16'h0000, 4'hF);

        // reset in the middle of a pass
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        idle_cycles(8);
        check_output("mid_offset2", 0, 1, 0, 16'h0026, 4'b1100);
        rst = 1'b1;
        tick();
        check_output("mid_reset", 1, 0, 0, 16'h0000, 4'hF);
        rst = 1'b0;
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        check_output("post_rst_start", 1, 0, 0, 16'h0000, 4'hF);
        tick();
        check_output("post_rst_ignored", 1, 0, 0, 16'h0000, 4'hF);

        // 16 beats without last close the message at full depth
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, 4'(i), 1'b0, 1'b0);
            if (i == 0 || i == 15) begin
                check_output($sformatf("ovf_beat%0d", i), 1, 0, 0, 16'h0000, 4'hF);
            end
            tick();
        end
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("ovf_first_window", 0, 1, 0, 16'h3210, 4'b0000);
        idle_cycles(60);
        check_output("ovf_last_offset", 0, 1, 0, 16'h000F, 4'b1110);
        idle_cycles(3);
        check_output("ovf_done", 0, 1, 1, 16'h000F, 4'b1110);
        tick();
        check_output("ovf_idle", 1, 0, 0, 16'h0000, 4'hF);

        // 17th beat opens a new message at buf[0]
        for (int i = 0; i < 17; i++) begin
            apply_stimulus(1'b1, (i == 16) ? 4'hA : 4'(i), 1'b0, 1'b0);
            tick();
        end
        apply_stimulus(1'b1, 4'hB, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        check_output("beat17_window", 0, 1, 0, 16'h00BA, 4'b1100);
        idle_cycles(7);
        check_output("beat17_done", 0, 1, 1, 16'h000B, 4'b1110);
        tick();

`ifdef SCROLL_LOOP_EN
        // looping single-code message pulses done every TICK_DIV cycles
        loop = 1'b1;
        apply_stimulus(1'b1, 4'h5, 1'b1, 1'b0);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 4'h0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            check_output($sformatf("loop_c%0d", c), 0, 1, (c % 4 == 0), 16'h0005, 4'b1110);
            tick();
        end
        loop = 1'b0;
        idle_cycles(3);
        check_output("loop_off_done", 0, 1, 1, 16'h0005, 4'b1110);
        tick();
        check_output("loop_off_idle", 1, 0, 0, 16'h0000, 4'hF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
